// File: rtl/fnd_scan_driver.sv
// fnd_scan_driver: binary to BCD conversion and a 4-digit
// multiplexed seven-segment scan with blanking and overflow dp.
module fnd_scan_driver #(
   parameter int SCAN_DIV = 100000,
   parameter int VALUE_W  = 14
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic [VALUE_W-1:0] i_value,
   input  logic               i_load,
   input  logic               i_en,
   output logic               o_busy,
   output logic               o_ovf,
   output logic [3:0]         o_digit,
   output logic [7:0]         o_fndFont
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [VALUE_W-1:0] MAX_V = VALUE_W'(9999);
   localparam logic [3:0] LAST_STEP = 4'(VALUE_W - 1);

   typedef enum logic {
      S_IDLE,
      S_CONV
   } state_t;

   state_t             state_q, state_d;
   logic [VALUE_W-1:0] bin_q, bin_d;
   logic [15:0]        bcd_q, bcd_d;
   logic [3:0]         step_q, step_d;
   logic               ovf_q, ovf_d;
   logic [15:0]        disp_q, disp_d;
   logic [PW-1:0]      presc_q, presc_d;
   logic [1:0]         idx_q, idx_d;
   logic [3:0]         digit_q, digit_d;
   logic [7:0]         font_q, font_d;

   logic [15:0]        adj;
   logic [15:0]        bcd_next;
   logic [3:0]         nib;
   logic [1:0]         msd;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [7:0] seg7(input logic [3:0] n);
      logic [7:0] f;
      case (n)
         4'd0:    f = 8'hC0;
         4'd1:    f = 8'hF9;
         4'd2:    f = 8'hA4;
         4'd3:    f = 8'hB0;
         4'd4:    f = 8'h99;
         4'd5:    f = 8'h92;
         4'd6:    f = 8'h82;
         4'd7:    f = 8'hF8;
         4'd8:    f = 8'h80;
         4'd9:    f = 8'h90;
         default: f = 8'hFF;
      endcase
      return f;
   endfunction

   // one double-dabble step: add 3 to big nibbles, then shift
   always_comb begin
      adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
             add3(bcd_q[7:4]), add3(bcd_q[3:0])};
      bcd_next = {adj[14:0], bin_q[VALUE_W-1]};
   end

   // conversion FSM: capture on load, step until the last bit
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      step_d  = step_q;
      ovf_d   = ovf_q;
      disp_d  = disp_q;
      case (state_q)
         S_IDLE: begin
            if (i_load) begin
               bin_d   = (i_value > MAX_V) ? MAX_V : i_value;
               ovf_d   = (i_value > MAX_V);
               bcd_d   = '0;
               step_d  = '0;
               state_d = S_CONV;
            end
         end
         S_CONV: begin
            bcd_d  = bcd_next;
            bin_d  = {bin_q[VALUE_W-2:0], 1'b0};
            step_d = step_q + 4'd1;
            if (step_q == LAST_STEP) begin
               disp_d  = bcd_next;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // free-running refresh prescaler and digit index
   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         idx_d   = idx_q + 2'd1;
      end
   end

   // digit select and font for the current index
   always_comb begin
      case (idx_q)
         2'd0:    nib = disp_q[3:0];
         2'd1:    nib = disp_q[7:4];
         2'd2:    nib = disp_q[11:8];
         default: nib = disp_q[15:12];
      endcase
      if (disp_q[15:12] != 4'd0)     msd = 2'd3;
      else if (disp_q[11:8] != 4'd0) msd = 2'd2;
      else if (disp_q[7:4] != 4'd0)  msd = 2'd1;
      else                           msd = 2'd0;
      digit_d = ~(4'b0001 << idx_q);
      font_d  = seg7(nib);
      if (idx_q > msd) begin
         font_d = 8'hFF;
      end
      if (ovf_q && (idx_q == 2'd0)) begin
         font_d = font_d & 8'h7F;
      end
      if (!i_en) begin
         digit_d = 4'b1111;
         font_d  = 8'hFF;
      end
   end

   // state and datapath registers
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         step_q  <= '0;
         ovf_q   <= 1'b0;
         disp_q  <= '0;
         presc_q <= '0;
         idx_q   <= '0;
         digit_q <= 4'b1111;
         font_q  <= 8'hFF;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         bcd_q   <= bcd_d;
         step_q  <= step_d;
         ovf_q   <= ovf_d;
         disp_q  <= disp_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         font_q  <= font_d;
      end
   end

   assign o_busy    = (state_q == S_CONV);
   assign o_ovf     = ovf_q;
   assign o_digit   = digit_q;
   assign o_fndFont = font_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb_fnd_scan_driver: directed checks of conversion,
// scan order, blanking, overflow, enable and reset abort.
module tb_fnd_scan_driver;

   logic        clk;
   logic        rst_n;
   logic [13:0] value;
   logic        load;
   logic        en;
   logic        busy;
   logic        ovf;
   logic [3:0]  digit;
   logic [7:0]  font;

   int total = 0;
   int bad   = 0;

   fnd_scan_driver #(
      .SCAN_DIV(4),
      .VALUE_W (14)
   ) dut (
      .i_clk    (clk),
      .i_reset_n(rst_n),
      .i_value  (value),
      .i_load   (load),
      .i_en     (en),
      .o_busy   (busy),
      .o_ovf    (ovf),
      .o_digit  (digit),
      .o_fndFont(font)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
      end
   endtask

   // wait for the first cycle of digit 0 becoming active
   task automatic sync_d0();
      logic [3:0] prev;
      logic       found;
      prev  = digit;
      found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (digit == 4'b1110 && prev != 4'b1110) begin
            found = 1'b1;
            break;
         end
         prev = digit;
      end
      chk("sync_d0", {15'd0, found}, 16'd1);
   endtask

   // one full scan: each digit held 4 cycles with its font
   task automatic check_scan(input string tag,
                             input logic [7:0] f0,
                             input logic [7:0] f1,
                             input logic [7:0] f2,
                             input logic [7:0] f3);
      logic [7:0] fx [4];
      logic [3:0] dx;
      fx[0] = f0;
      fx[1] = f1;
      fx[2] = f2;
      fx[3] = f3;
      sync_d0();
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 4; c++) begin
            if (d != 0 || c != 0) @(negedge clk);
            dx = ~(4'b0001 << d);
            chk({tag, "_dig"}, {12'd0, digit}, {12'd0, dx});
            chk({tag, "_font"}, {8'd0, font}, {8'd0, fx[d]});
         end
      end
   endtask

   // load a value, optionally poke a second load while busy
   task automatic do_load(input string tag,
                          input logic [13:0] v,
                          input logic exp_ovf,
                          input int inj_at,
                          input logic [13:0] inj_v);
      int cnt;
      @(negedge clk);
      value = v;
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk({tag, "_ovf0"}, {15'd0, ovf}, {15'd0, exp_ovf});
      cnt = 0;
      for (int j = 0; j < 40; j++) begin
         if (!busy) break;
         cnt++;
         if (cnt == inj_at) begin
            value = inj_v;
            load  = 1'b1;
         end else begin
            load = 1'b0;
         end
         @(negedge clk);
      end
      load = 1'b0;
      chk({tag, "_busy"}, 16'(cnt), 16'd14);
      chk({tag, "_ovf1"}, {15'd0, ovf}, {15'd0, exp_ovf});
   endtask

   initial begin
      rst_n = 1'b0;
      value = '0;
      load  = 1'b0;
      en    = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_dig", {12'd0, digit}, 16'h000F);
      chk("rst_font", {8'd0, font}, 16'h00FF);
      rst_n = 1'b1;
      #1;
      chk("rel_dig", {12'd0, digit}, 16'h000F);
      chk("rel_font", {8'd0, font}, 16'h00FF);
      chk("rel_busy", {15'd0, busy}, 16'd0);
      chk("rel_ovf", {15'd0, ovf}, 16'd0);
      check_scan("zero", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

      do_load("l1234", 14'd1234, 1'b0, 0, 14'd0);
      check_scan("s1234", 8'h99, 8'hB0, 8'hA4, 8'hF9);
      check_scan("s1234b", 8'h99, 8'hB0, 8'hA4, 8'hF9);

      do_load("l7", 14'd7, 1'b0, 0, 14'd0);
      check_scan("s7", 8'hF8, 8'hFF, 8'hFF, 8'hFF);
      do_load("l0", 14'd0, 1'b0, 0, 14'd0);
      check_scan("s0", 8'hC0, 8'hFF, 8'hFF, 8'hFF);

      do_load("l12000", 14'd12000, 1'b1, 0, 14'd0);
      check_scan("sovf", 8'h10, 8'h90, 8'h90, 8'h90);
      do_load("l5", 14'd5, 1'b0, 0, 14'd0);
      check_scan("s5", 8'h92, 8'hFF, 8'hFF, 8'hFF);

      do_load("lign", 14'd1234, 1'b0, 5, 14'd42);
      check_scan("sign", 8'h99, 8'hB0, 8'hA4, 8'hF9);

      @(negedge clk);
      value = 14'd9876;
      load  = 1'b1;
      @(negedge clk);
      load = 1'b0;
      chk("mid_busy0", {15'd0, busy}, 16'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_busy", {15'd0, busy}, 16'd0);
      chk("mid_ovf", {15'd0, ovf}, 16'd0);
      chk("mid_dig", {12'd0, digit}, 16'h000F);
      chk("mid_font", {8'd0, font}, 16'h00FF);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_scan("smid", 8'hC0, 8'hFF, 8'hFF, 8'hFF);
      chk("mid_busy2", {15'd0, busy}, 16'd0);

      do_load("len", 14'd1234, 1'b0, 0, 14'd0);
      sync_d0();
      en = 1'b0;
      @(negedge clk);
      chk("en0_dig", {12'd0, digit}, 16'h000F);
      chk("en0_font", {8'd0, font}, 16'h00FF);
      repeat (4) @(negedge clk);
      chk("en0_dig2", {12'd0, digit}, 16'h000F);
      chk("en0_font2", {8'd0, font}, 16'h00FF);
      en = 1'b1;
      @(negedge clk);
      chk("en1_dig", {12'd0, digit}, 16'h000D);
      chk("en1_font", {8'd0, font}, 16'h00B0);
      check_scan("sen", 8'h99, 8'hB0, 8'hA4, 8'hF9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
